// File: rtl/iter_multdiv.sv
// iter_multdiv: iterative signed 32-bit multiply / divide unit.
// A request seen in IDLE latches operand magnitudes and sign flags, then
// 32 single-bit steps run (shift-add for multiply, restoring for divide).
// The sign-corrected result and exception flag are registered on the last
// step, and data_resultRDY pulses for the one DONE cycle that follows.
// DONE always falls back to IDLE, so a request level that is still held
// from the finished instruction cannot restart the unit early.

module iter_multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  count;
    logic [5:0]  count_next;
    logic [63:0] work;
    logic [63:0] work_next;
    logic [31:0] operand;
    logic [31:0] operand_next;
    logic        sign_a;
    logic        sign_a_next;
    logic        sign_b;
    logic        sign_b_next;
    logic        a_nonzero;
    logic        a_nonzero_next;

    logic [31:0] result_next;
    logic        exception_next;
    logic        rdy_next;

    logic [31:0] mag_a;
    logic [31:0] mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic        mul_neg;
    logic [63:0] prod_signed;
    logic        mul_exc;

    logic [63:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_step;
    logic [31:0] quot_mag;
    logic        div_neg;
    logic [31:0] div_res;
    logic        div_exc;

    logic        last_step;

    // Operand magnitudes; 0x80000000 maps onto unsigned 2^31 without overflow.
    always_comb begin
        mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
        mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    end

    // One multiply step: conditionally add the multiplicand into the upper
    // half, then shift the whole 64-bit product/multiplier register right.
    always_comb begin
        mul_sum     = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
        mul_step    = {mul_sum, work[31:1]};
        mul_neg     = sign_a ^ sign_b;
        prod_signed = mul_neg ? (~mul_step + 64'd1) : mul_step;
        mul_exc     = !((&prod_signed[63:31]) || !(|prod_signed[63:31]));
    end

    // One restoring divide step: shift remainder:dividend left, trial
    // subtract the divisor and keep the difference only if it did not borrow.
    always_comb begin
        div_shift = {work[62:0], 1'b0};
        div_diff  = {1'b0, div_shift[63:32]} - {1'b0, operand};
        div_step  = div_diff[32] ? div_shift
                                 : {div_diff[31:0], div_shift[31:1], 1'b1};
        quot_mag  = div_step[31:0];
        div_neg   = (sign_a ^ sign_b) && a_nonzero;
    end

    // Final quotient with divide-by-zero and 0x80000000/-1 overflow handling.
    always_comb begin
        div_res = 32'd0;
        div_exc = 1'b0;
        if (operand == 32'd0) begin
            div_res = 32'd0;
            div_exc = 1'b1;
        end else if (!div_neg && quot_mag[31]) begin
            div_res = quot_mag;
            div_exc = 1'b1;
        end else begin
            div_res = div_neg ? (~quot_mag + 32'd1) : quot_mag;
            div_exc = 1'b0;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts.
    always_comb begin
        state_next     = state;
        count_next     = count;
        work_next      = work;
        operand_next   = operand;
        sign_a_next    = sign_a;
        sign_b_next    = sign_b;
        a_nonzero_next = a_nonzero;
        result_next    = data_result;
        exception_next = data_exception;
        rdy_next       = 1'b0;
        last_step      = (count == 6'd31);

        case (state)
            IDLE: begin
                if (ctrl_MULT) begin
                    state_next     = MUL;
                    count_next     = 6'd0;
                    operand_next   = mag_a;
                    work_next      = {32'd0, mag_b};
                    sign_a_next    = data_operandA[31];
                    sign_b_next    = data_operandB[31];
                    a_nonzero_next = |data_operandA;
                end else if (ctrl_DIV) begin
                    state_next     = DIV;
                    count_next     = 6'd0;
                    operand_next   = mag_b;
                    work_next      = {32'd0, mag_a};
                    sign_a_next    = data_operandA[31];
                    sign_b_next    = data_operandB[31];
                    a_nonzero_next = |data_operandA;
                end
            end
            MUL: begin
                work_next  = mul_step;
                count_next = count + 6'd1;
                if (last_step) begin
                    state_next     = DONE;
                    result_next    = prod_signed[31:0];
                    exception_next = mul_exc;
                    rdy_next       = 1'b1;
                end
            end
            DIV: begin
                work_next  = div_step;
                count_next = count + 6'd1;
                if (last_step) begin
                    state_next     = DONE;
                    result_next    = div_res;
                    exception_next = div_exc;
                    rdy_next       = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                count_next = 6'd0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; outputs come straight from these flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count          <= 6'd0;
            work           <= 64'd0;
            operand        <= 32'd0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            a_nonzero      <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            count          <= count_next;
            work           <= work_next;
            operand        <= operand_next;
            sign_a         <= sign_a_next;
            sign_b         <= sign_b_next;
            a_nonzero      <= a_nonzero_next;
            data_result    <= result_next;
            data_exception <= exception_next;
            data_resultRDY <= rdy_next;
        end
    end

endmodule

// File: doc/iter_multdiv.md
# iter_multdiv

Iterative signed 32-bit multiply/divide unit that sits beside the execute stage of the 5-stage pipeline. It accepts operands from the execute-stage ALU input muxes. The pipeline holds the multiply/divide instruction, freezing fetch/decode and the M/W latch writes, until `data_resultRDY` pulses. On that pulse the pipeline takes `data_result` and `data_exception` into its writeback path.

## Interface
- No parameters; datapath width fixed at 32, iteration count fixed at 32.
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- data_operandA  in  32  signed multiplicand / dividend; sampled only at the start edge.
- data_operandB  in  32  signed multiplier / divisor; sampled only at the start edge.
- ctrl_MULT  in  1  multiply request level; the pipeline holds it high while stalled.
- ctrl_DIV  in  1  divide request level; same hold behaviour.
- data_result  out  32  low 32 bits of the product, or the quotient; registered.
- data_exception  out  1  multiply overflow, divide-by-zero, or divide overflow; registered.
- data_resultRDY  out  1  one-cycle completion pulse; registered.

## Operation
- States: IDLE, MUL, DIV, DONE; 6-bit iteration counter; 64-bit working register; 32-bit operand register; sign flags.
- IDLE:
  - ctrl_MULT=1: latch operands, enter MUL, counter=0.
  - else ctrl_DIV=1: latch operands, enter DIV, counter=0.
  - Both high: MULT wins. Neither high: stay.
- MUL: one shift-add step per cycle on operand magnitudes; counter increments each cycle.
  - On the 32nd step, register the sign-corrected product into data_result/data_exception and go to DONE.
- DIV: one restoring step per cycle on magnitudes; counter increments each cycle.
  - On the 32nd step, register the quotient and exception and go to DONE.
- DONE: data_resultRDY=1 for exactly this cycle; next edge returns to IDLE unconditionally.
  - ctrl_* are ignored in DONE, so a request still held from the just-finished instruction never restarts the unit.
- Arithmetic rules:
  - Product: full 64-bit signed product P. data_result = P[31:0]. Exception = 1 if P is outside [-2^31, 2^31-1].
  - Quotient: truncated toward zero; remainder discarded. Quotient is negative iff operand signs differ and the dividend is nonzero.
  - Divisor 0: data_result=0, exception=1. Full latency still applies.
  - 0x80000000 / -1: data_result=0x80000000, exception=1.
  - Magnitude of 0x80000000 is handled as unsigned 2^31. No intermediate overflow.
- data_result and data_exception hold their last value until the next completion. They are not cleared at start.
- Operand changes after the start edge do not affect the result.

## Timing
- Reset (reset=0, any time, asynchronous): state=IDLE, counter=0; data_result=0, data_exception=0, data_resultRDY=0; working registers=0.
- Reset mid-operation aborts the operation with no RDY pulse. The first request after release starts fresh.
- Latency: start edge E0 (in IDLE with a request). Steps at E1..E32. data_resultRDY is high from E32 to E33, i.e. 32 cycles after E0. Identical for multiply and divide.
- Throughput: back-to-back requests start no earlier than E34. The IDLE cycle after DONE is mandatory.
- data_resultRDY never stays high for two consecutive cycles. It is never high outside DONE.
- All outputs are direct flop outputs, with no combinational path from inputs to outputs.

## Test plan
- Multiply: A=6, B=7, ctrl_MULT held high -> RDY pulses exactly 32 cycles after start; result=42, exception=0. Then drop ctrl_MULT -> unit returns to IDLE with no second pulse.
- Multiply overflow: A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1. Also A=-3, B=5 -> result=0xFFFFFFF1, exception=0.
- Divide signs: -7/2 -> 0xFFFFFFFD, exc=0. 7/-2 -> 0xFFFFFFFD, exc=0. 0x80000000/1 -> 0x80000000, exc=0. 0/-5 -> 0, exc=0.
- Divide exceptions: 5/0 -> result=0, exc=1 at 32-cycle latency. 0x80000000/-1 -> 0x80000000, exc=1.
- Reset mid-operation: start 100/3, assert reset low at cycle 10 -> outputs 0 immediately and no RDY. Release, request 100/3 -> 33 after the full 32 cycles.
- Held/simultaneous requests:
  - ctrl_MULT and ctrl_DIV both high, A=9, B=3 -> result=27.
  - ctrl_MULT kept high through DONE -> exactly one pulse per start; the next start occurs at the IDLE edge after DONE.
  - Operands changed at cycle 5 -> result unchanged.
